stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/stopwatch_ctrl_mod_counter.sv | 36 +++
 rtl/stopwatch_ctrl.sv | 154 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller slice.
// Holds the controller state encoding, default field widths/limits and
// the adjust-field select values.
package stopwatch_pkg;

  localparam int unsigned DEF_TW      = 6;
  localparam int unsigned DEF_MAX_MIN = 59;
  localparam int unsigned DEF_MAX_SEC = 59;

  localparam logic SEL_MIN = 1'b0;
  localparam logic SEL_SEC = 1'b1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PAUSE = 2'd1,
    S_ADJ   = 2'd2
  } state_t;

endpackage

// File: rtl/stopwatch_ctrl_mod_counter.sv
// Modulo counter for one time field: counts 0..MAX and wraps to 0.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   inc       - advance by one this cycle
//   clr       - synchronous clear to 0 (overrides inc)
//   value     - current count (registered)
//   carry_c   - combinational: inc while value is at MAX (wrap this cycle)
module mod_counter #(
  parameter int unsigned TW  = 6,
  parameter int unsigned MAX = 59
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [TW-1:0] value,
  output logic          carry_c
);

  logic at_max;

  assign at_max  = (value == TW'(MAX));
  assign carry_c = inc & at_max;

  // Count register with wrap at MAX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= at_max ? '0 : value + TW'(1);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: owns MM:SS time, run/pause/adjust FSM,
// divider clear and display blink qualifier.
// Optional feature macro: HOLD_AT_MAX_EN -- when defined, a run-mode tick at
// MAX_MIN:MAX_SEC holds the time and forces pause instead of wrapping.
// Ports:
//   master_clock, rst       - clock, asynchronous active-high reset
//   clock1hz / clock2hz     - divider levels; rising edge = count / adjust tick
//   clock_adjust            - divider blink level (shown only while adjusting)
//   pause_pulse, clr_pulse  - one-cycle debounced button presses
//   adj, sel                - adjust-mode switch, field select (0 min, 1 sec)
//   minutes, seconds        - current time
//   running                 - high in S_RUN
//   blink_on                - display enable qualifier (combinational)
//   div_clr                 - one-cycle clear to the divider
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MIN = DEF_MAX_MIN,
  parameter int unsigned MAX_SEC = DEF_MAX_SEC,
  parameter int unsigned TW      = DEF_TW
) (
  input  logic          master_clock,
  input  logic          rst,
  input  logic          clock1hz,
  input  logic          clock2hz,
  input  logic          clock_adjust,
  input  logic          pause_pulse,
  input  logic          clr_pulse,
  input  logic          adj,
  input  logic          sel,
  output logic [TW-1:0] minutes,
  output logic [TW-1:0] seconds,
  output logic          running,
  output logic          blink_on,
  output logic          div_clr
);

  state_t state, next_state;
  logic   resume_run, next_resume;
  logic   next_div_clr;
  logic   prev1, prev2;
  logic   tick1, tick2;
  logic   run_adv, adj_tick, clr;
  logic   sec_inc, min_inc, sec_carry, min_carry;

  assign tick1 = clock1hz & ~prev1;
  assign tick2 = clock2hz & ~prev2;

  // Edge-detect history and FSM state register
  always_ff @(posedge master_clock or posedge rst) begin
    if (rst) begin
      prev1      <= 1'b0;
      prev2      <= 1'b0;
      state      <= S_PAUSE;
      resume_run <= 1'b0;
      div_clr    <= 1'b0;
    end else begin
      prev1      <= clock1hz;
      prev2      <= clock2hz;
      state      <= next_state;
      resume_run <= next_resume;
      div_clr    <= next_div_clr;
    end
  end

  // Next-state and counter control; clear wins over everything and holds state
  always_comb begin
    next_state   = state;
    next_resume  = resume_run;
    next_div_clr = 1'b0;
    run_adv      = 1'b0;
    adj_tick     = 1'b0;
    clr          = 1'b0;
    if (clr_pulse) begin
      clr          = 1'b1;
      next_div_clr = 1'b1;
    end else begin
      case (state)
        S_RUN: begin
          if (adj) begin
            next_state  = S_ADJ;
            next_resume = 1'b1;
          end else begin
            // A tick coincident with pause is still applied
            if (tick1) begin
`ifdef HOLD_AT_MAX_EN
              if ((minutes == TW'(MAX_MIN)) && (seconds == TW'(MAX_SEC))) begin
                next_state = S_PAUSE;
              end else begin
                run_adv = 1'b1;
              end
`else
              run_adv = 1'b1;
`endif
            end
            if (pause_pulse) begin
              next_state = S_PAUSE;
            end
          end
        end
        S_PAUSE: begin
          if (adj) begin
            next_state  = S_ADJ;
            next_resume = 1'b0;
          end else if (pause_pulse) begin
            // Restart divider so the first tick is a full period away
            next_state   = S_RUN;
            next_div_clr = 1'b1;
          end
        end
        S_ADJ: begin
          if (!adj) begin
            next_state = resume_run ? S_RUN : S_PAUSE;
          end else if (tick2) begin
            adj_tick = 1'b1;
          end
        end
        default: begin
          next_state = S_PAUSE;
        end
      endcase
    end
  end

  // Seconds carry only propagates while counting; adjust wraps fields independently
  assign sec_inc = run_adv | (adj_tick & (sel == SEL_SEC));
  assign min_inc = (run_adv & sec_carry) | (adj_tick & (sel == SEL_MIN));

  mod_counter #(.TW(TW), .MAX(MAX_SEC)) u_sec (
    .clk     (master_clock),
    .rst     (rst),
    .inc     (sec_inc),
    .clr     (clr),
    .value   (seconds),
    .carry_c (sec_carry)
  );

  mod_counter #(.TW(TW), .MAX(MAX_MIN)) u_min (
    .clk     (master_clock),
    .rst     (rst),
    .inc     (min_inc),
    .clr     (clr),
    .value   (minutes),
    .carry_c (min_carry)
  );

  assign running  = (state == S_RUN);
  assign blink_on = (state == S_ADJ) ? clock_adjust : 1'b1;

  // Minutes wrap carries nowhere; tie off the unused carry
  logic unused_ok;
  assign unused_ok = min_carry;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl.
module tb_stopwatch_ctrl;

  logic       master_clock = 1'b0;
  logic       rst = 1'b1;
  logic       clock1hz = 1'b0;
  logic       clock2hz = 1'b0;
  logic       clock_adjust = 1'b0;
  logic       pause_pulse = 1'b0;
  logic       clr_pulse = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       blink_on;
  logic       div_clr;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl dut (
    .master_clock (master_clock),
    .rst          (rst),
    .clock1hz     (clock1hz),
    .clock2hz     (clock2hz),
    .clock_adjust (clock_adjust),
    .pause_pulse  (pause_pulse),
    .clr_pulse    (clr_pulse),
    .adj          (adj),
    .sel          (sel),
    .minutes      (minutes),
    .seconds      (seconds),
    .running      (running),
    .blink_on     (blink_on),
    .div_clr      (div_clr)
  );

  always #5 master_clock = ~master_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge master_clock);
    #1;
  endtask

  task automatic tick1(input int n);
    for (int i = 0; i < n; i++) begin
      clock1hz = 1'b1;
      cyc();
      clock1hz = 1'b0;
      cyc();
    end
  endtask

  task automatic tick2(input int n);
    for (int i = 0; i < n; i++) begin
      clock2hz = 1'b1;
      cyc();
      clock2hz = 1'b0;
      cyc();
    end
  endtask

  initial begin
    // Reset state
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    check("rst_min", 32'(minutes), 0);
    check("rst_sec", 32'(seconds), 0);
    check("rst_running", 32'(running), 0);
    check("rst_blink", 32'(blink_on), 1);
    check("rst_divclr", 32'(div_clr), 0);

    // Start: one-cycle divider clear, then 60 ticks -> 01:00
    pause_pulse = 1'b1;
    cyc();
    pause_pulse = 1'b0;
    check("start_running", 32'(running), 1);
    check("start_divclr_hi", 32'(div_clr), 1);
    cyc();
    check("start_divclr_lo", 32'(div_clr), 0);
    tick1(1);
    check("first_tick_sec", 32'(seconds), 1);
    tick1(59);
    check("t60_min", 32'(minutes), 1);
    check("t60_sec", 32'(seconds), 0);

    // Clear while running keeps running
    clr_pulse = 1'b1;
    cyc();
    clr_pulse = 1'b0;
    check("clr_run_min", 32'(minutes), 0);
    check("clr_run_divclr", 32'(div_clr), 1);
    check("clr_run_running", 32'(running), 1);

    // Adjust seconds from 00:10 by 55 -> 00:05, no carry into minutes
    tick1(10);
    check("t10_sec", 32'(seconds), 10);
    adj = 1'b1;
    sel = 1'b1;
    cyc();
    check("adj_running", 32'(running), 0);
    tick2(55);
    check("adj_sec", 32'(seconds), 5);
    check("adj_min", 32'(minutes), 0);
    pause_pulse = 1'b1;
    cyc();
    pause_pulse = 1'b0;
    clock_adjust = 1'b1;
    #1;
    check("adj_blink_hi", 32'(blink_on), 1);
    clock_adjust = 1'b0;
    #1;
    check("adj_blink_lo", 32'(blink_on), 0);
    tick1(2);
    check("adj_tick1_ignored", 32'(seconds), 5);
    adj = 1'b0;
    cyc();
    check("adj_exit_running", 32'(running), 1);
    check("adj_exit_divclr", 32'(div_clr), 0);

    // Tick and pause together at 00:07 -> 00:08 paused
    tick1(2);
    check("t07_sec", 32'(seconds), 7);
    clock1hz = 1'b1;
    pause_pulse = 1'b1;
    cyc();
    clock1hz = 1'b0;
    pause_pulse = 1'b0;
    check("tick_pause_sec", 32'(seconds), 8);
    check("tick_pause_running", 32'(running), 0);
    cyc();
    check("blink_paused", 32'(blink_on), 1);

    // Clear coincident with tick in run -> 00:00
    pause_pulse = 1'b1;
    cyc();
    pause_pulse = 1'b0;
    cyc();
    clock1hz = 1'b1;
    clr_pulse = 1'b1;
    cyc();
    clock1hz = 1'b0;
    clr_pulse = 1'b0;
    check("clr_tick_sec", 32'(seconds), 0);
    check("clr_tick_divclr", 32'(div_clr), 1);
    check("clr_tick_running", 32'(running), 1);
    cyc();

    // Adjust rising with tick in run: adjust wins
    adj = 1'b1;
    clock1hz = 1'b1;
    cyc();
    clock1hz = 1'b0;
    check("adj_vs_tick_sec", 32'(seconds), 0);
    check("adj_vs_tick_running", 32'(running), 0);
    cyc();

    // Preload 59:58 and run across the top
    sel = 1'b0;
    tick2(59);
    sel = 1'b1;
    tick2(58);
    check("pre_min", 32'(minutes), 59);
    check("pre_sec", 32'(seconds), 58);
    adj = 1'b0;
    cyc();
    tick1(1);
    check("max_min", 32'(minutes), 59);
    check("max_sec", 32'(seconds), 59);
    tick1(1);
`ifdef HOLD_AT_MAX_EN
    check("top_min", 32'(minutes), 59);
    check("top_sec", 32'(seconds), 59);
    check("top_running", 32'(running), 0);
`else
    check("top_min", 32'(minutes), 0);
    check("top_sec", 32'(seconds), 0);
    check("top_running", 32'(running), 1);
`endif

    // Set 03:17, run, then asynchronous reset mid-cycle
    clr_pulse = 1'b1;
    cyc();
    clr_pulse = 1'b0;
    adj = 1'b1;
    sel = 1'b0;
    cyc();
    tick2(3);
    sel = 1'b1;
    tick2(17);
    adj = 1'b0;
    cyc();
`ifdef HOLD_AT_MAX_EN
    pause_pulse = 1'b1;
    cyc();
    pause_pulse = 1'b0;
    cyc();
`endif
    check("set_min", 32'(minutes), 3);
    check("set_sec", 32'(seconds), 17);
    check("set_running", 32'(running), 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_min", 32'(minutes), 0);
    check("arst_sec", 32'(seconds), 0);
    check("arst_running", 32'(running), 0);
    check("arst_blink", 32'(blink_on), 1);
    cyc();
    rst = 1'b0;
    tick1(2);
    check("post_rst_sec", 32'(seconds), 0);
    check("post_rst_running", 32'(running), 0);
    pause_pulse = 1'b1;
    cyc();
    pause_pulse = 1'b0;
    check("post_rst_start", 32'(running), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
